program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 149 ++++++++++++++
 tb/tb_program_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed word stream into memory at addresses 0..N-1,
// pulses execute, then passes memory to the cpu until it halts and a new stream may follow.
module program_loader #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned MEM_ADDR_SIZE = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic [MEM_ADDR_SIZE-1:0] cpu_mem_address,
    input  logic [WORD_SIZE-1:0]     cpu_mem_write_data,
    input  logic                     cpu_mem_read,
    input  logic                     cpu_mem_write,
    output logic [WORD_SIZE-1:0]     cpu_mem_read_data,
    output logic [MEM_ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]     mem_write_data,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [WORD_SIZE-1:0]     mem_read_data,
    input  logic                     cpu_halted,
    output logic                     execute,
    output logic                     loading,
    output logic                     error
);

    localparam int unsigned MemWords = 1 << MEM_ADDR_SIZE;

    typedef enum logic [3:0] {
        StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StStart, StRun, StDone, StError
    } state_e;

    state_e                   state_q, state_d;
    logic [15:0]              count_q, count_d;
    logic [15:0]              word_q, word_d;
    // One extra bit so a full-memory image (N = 2^MEM_ADDR_SIZE) reaches N without wrapping.
    logic [MEM_ADDR_SIZE:0]   addr_q, addr_d;
    logic [MEM_ADDR_SIZE:0]   addr_next;
    logic [15:0]              len_full;
    logic                     xfer;

    assign xfer      = in_valid & in_ready;
    assign len_full  = {count_q[15:8], in_data};
    assign addr_next = addr_q + (MEM_ADDR_SIZE + 1)'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StLenHi;
            count_q <= '0;
            word_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        addr_d  = addr_q;
        unique case (state_q)
            StLenHi, StDone: begin
                if (xfer) begin
                    count_d[15:8] = in_data;
                    state_d       = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    count_d[7:0] = in_data;
                    addr_d       = '0;
                    if (len_full == 16'd0) begin
                        state_d = StStart;
                    end else if (32'(len_full) > MemWords) begin
                        state_d = StError;
                    end else begin
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (xfer) begin
                    word_d[15:8] = in_data;
                    state_d      = StDataLo;
                end
            end
            StDataLo: begin
                if (xfer) begin
                    word_d[7:0] = in_data;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                addr_d  = addr_next;
                state_d = (32'(addr_next) == 32'(count_q)) ? StStart : StDataHi;
            end
            StStart: state_d = StRun;
            StRun: begin
                if (cpu_halted) begin
                    state_d = StDone;
                end
            end
            StError: state_d = StError;
            default: state_d = StLenHi;
        endcase
    end

    // Strobes are gated by reset so an aborted load or run touches memory no further.
    always_comb begin
        in_ready       = 1'b0;
        loading        = 1'b0;
        execute        = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        unique case (state_q)
            StLenHi, StLenLo, StDataHi, StDataLo: begin
                in_ready = ~reset;
                loading  = 1'b1;
            end
            StDone: in_ready = ~reset;
            StWrite: begin
                loading        = 1'b1;
                mem_write      = ~reset;
                mem_address    = addr_q[MEM_ADDR_SIZE-1:0];
                mem_write_data = WORD_SIZE'(word_q);
            end
            StStart: execute = ~reset;
            StRun: begin
                mem_address    = cpu_mem_address;
                mem_write_data = cpu_mem_write_data;
                mem_read       = cpu_mem_read & ~reset;
                mem_write      = cpu_mem_write & ~reset;
            end
            default: begin
            end
        endcase
    end

    assign error             = (state_q == StError);
    assign cpu_mem_read_data = mem_read_data;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized bench; a byte-stream model predicts the memory image,
// execute pulse timing and overflow behaviour of program_loader.
module tb_program_loader;
    localparam int unsigned WS = 16;
    localparam int unsigned AS = 8;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [15:0] word_q_t[$];

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic [AS-1:0] cpu_mem_address = '0;
    logic [WS-1:0] cpu_mem_write_data = '0;
    logic          cpu_mem_read = 1'b0;
    logic          cpu_mem_write = 1'b0;
    logic [WS-1:0] cpu_mem_read_data;
    logic [AS-1:0] mem_address;
    logic [WS-1:0] mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [WS-1:0] mem_read_data = '0;
    logic          cpu_halted = 1'b0;
    logic          execute;
    logic          loading;
    logic          error;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int exec_count = 0;
    int exec_cycle = -1;
    int last_write_cycle = -1;
    int last_xfer_cycle = -1;
    int            wr_addr_log[$];
    logic [WS-1:0] wr_data_log[$];

    program_loader #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS)) dut (
        .clock              (clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .cpu_mem_address    (cpu_mem_address),
        .cpu_mem_write_data (cpu_mem_write_data),
        .cpu_mem_read       (cpu_mem_read),
        .cpu_mem_write      (cpu_mem_write),
        .cpu_mem_read_data  (cpu_mem_read_data),
        .mem_address        (mem_address),
        .mem_write_data     (mem_write_data),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_read_data      (mem_read_data),
        .cpu_halted         (cpu_halted),
        .execute            (execute),
        .loading            (loading),
        .error              (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (mem_write) begin
            wr_addr_log.push_back(int'(mem_address));
            wr_data_log.push_back(mem_write_data);
            last_write_cycle <= cycle;
        end
        if (execute) begin
            exec_count <= exec_count + 1;
            exec_cycle <= cycle;
        end
        if (in_valid && in_ready) last_xfer_cycle <= cycle;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int stream_len(input byte_q_t s);
        return (int'(s[0]) << 8) | int'(s[1]);
    endfunction

    // Expected memory image: word i at address i, empty when the length is zero or too big.
    function automatic word_q_t expected_words(input byte_q_t s);
        word_q_t w;
        int      n;
        n = stream_len(s);
        if (n <= (1 << AS)) begin
            for (int i = 0; i < n; i++) w.push_back({s[2 + 2 * i], s[3 + 2 * i]});
        end
        return w;
    endfunction

    function automatic byte_q_t pack_stream(input logic [63:0] v, input int len);
        byte_q_t s;
        for (int i = 0; i < len; i++) s.push_back(v[8 * (len - 1 - i) +: 8]);
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b0;
        cpu_mem_read = 1'b0;
        cpu_mem_write = 1'b0;
        cpu_halted = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
        int gaps;
        int budget;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        @(negedge clock);
        repeat (gaps) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b1;
        in_data = b;
        budget = 20;
        ok = 1'b0;
        while (!in_ready && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (in_ready) begin
            @(posedge clock);
            #1;
            ok = 1'b1;
        end
    endtask

    task automatic send_stream(input string name, input byte_q_t s, input int gap_max);
        bit ok;
        foreach (s[i]) begin
            send_byte(s[i], gap_max, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL %s byte_accept: byte %0d not accepted within budget", name, i);
                break;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_load_stream(input string name, input byte_q_t s, input int gap_max);
        word_q_t want;
        int      wb;
        int      eb;
        int      n_new;
        bit      want_err;
        want = expected_words(s);
        want_err = stream_len(s) > (1 << AS);
        wb = wr_addr_log.size();
        eb = exec_count;
        send_stream(name, s, gap_max);
        repeat (6) @(negedge clock);
        n_new = wr_addr_log.size() - wb;
        checks++;
        if (n_new != want.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, n_new, want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                checks++;
                if (wr_addr_log[wb + i] != i || wr_data_log[wb + i] !== want[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got %h@%0d want %h@%0d", name, i,
                             wr_data_log[wb + i], wr_addr_log[wb + i], want[i], i);
                end
            end
        end
        checks++;
        if (exec_count - eb != (want_err ? 0 : 1)) begin
            errors++;
            $display("FAIL %s exec_count: got %0d want %0d", name, exec_count - eb,
                     want_err ? 0 : 1);
        end else if (!want_err) begin
            checks++;
            if (want.size() > 0 && exec_cycle != last_write_cycle + 1) begin
                errors++;
                $display("FAIL %s exec_timing: got cycle %0d want %0d", name, exec_cycle,
                         last_write_cycle + 1);
            end else if (want.size() == 0 && exec_cycle != last_xfer_cycle + 1) begin
                errors++;
                $display("FAIL %s exec_timing: got cycle %0d want %0d", name, exec_cycle,
                         last_xfer_cycle + 1);
            end
        end
        checks++;
        if (error !== want_err || in_ready !== 1'b0 || loading !== 1'b0) begin
            errors++;
            $display("FAIL %s final_state: got err=%b rdy=%b ld=%b want err=%b rdy=0 ld=0",
                     name, error, in_ready, loading, want_err);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (2) @(negedge clock);
        checks++;
        if (in_ready !== 1'b0 || execute !== 1'b0 || mem_write !== 1'b0 ||
            mem_read !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got rdy=%b ex=%b mw=%b mr=%b err=%b want all 0",
                     in_ready, execute, mem_write, mem_read, error);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (loading !== 1'b1 || in_ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ld=%b rdy=%b err=%b want 1 1 0",
                     loading, in_ready, error);
        end
    endtask

    task automatic test_basic();
        test_load_stream("basic", pack_stream(64'h0002_1234_ABCD, 6), 0);
    endtask

    task automatic test_run_passthrough();
        @(negedge clock);
        cpu_mem_address = 8'h05;
        cpu_mem_write = 1'b1;
        cpu_mem_read = 1'b0;
        cpu_mem_write_data = 16'h00FF;
        #1;
        checks++;
        if (mem_address !== 8'h05 || mem_write !== 1'b1 || mem_write_data !== 16'h00FF ||
            mem_read !== 1'b0) begin
            errors++;
            $display("FAIL run_fixed: got a=%h w=%b d=%h r=%b want 05 1 00ff 0",
                     mem_address, mem_write, mem_write_data, mem_read);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            cpu_mem_address = AS'($urandom);
            cpu_mem_write_data = WS'($urandom);
            cpu_mem_read = 1'($urandom);
            cpu_mem_write = 1'($urandom);
            mem_read_data = WS'($urandom);
            #1;
            checks++;
            if (mem_address !== cpu_mem_address || mem_write_data !== cpu_mem_write_data ||
                mem_read !== cpu_mem_read || mem_write !== cpu_mem_write ||
                cpu_mem_read_data !== mem_read_data || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL run_random[%0d]: got a=%h d=%h r=%b w=%b rd=%h rdy=%b", i,
                         mem_address, mem_write_data, mem_read, mem_write, cpu_mem_read_data,
                         in_ready);
            end
        end
        @(negedge clock);
        cpu_mem_read = 1'b0;
        cpu_mem_write = 1'b0;
    endtask

    task automatic test_halt_reload();
        @(negedge clock);
        cpu_halted = 1'b1;
        @(negedge clock);
        cpu_halted = 1'b0;
        cpu_mem_write = 1'b1;
        cpu_mem_read = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || loading !== 1'b0 || mem_write !== 1'b0 ||
            mem_read !== 1'b0 || execute !== 1'b0) begin
            errors++;
            $display("FAIL done_state: got rdy=%b ld=%b mw=%b mr=%b ex=%b want 1 0 0 0 0",
                     in_ready, loading, mem_write, mem_read, execute);
        end
        cpu_mem_write = 1'b0;
        cpu_mem_read = 1'b0;
        test_load_stream("reload", pack_stream(64'h0001_BEEF, 4), 0);
    endtask

    task automatic test_empty();
        do_reset();
        test_load_stream("empty", pack_stream(64'h0000, 2), 0);
    endtask

    task automatic test_overflow();
        do_reset();
        test_load_stream("overflow", pack_stream(64'h0101, 2), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            in_valid = 1'($urandom);
            in_data = 8'($urandom);
            cpu_mem_write = 1'($urandom);
            cpu_mem_read = 1'($urandom);
            mem_read_data = WS'($urandom);
            #1;
            checks++;
            if (error !== 1'b1 || in_ready !== 1'b0 || mem_write !== 1'b0 ||
                mem_read !== 1'b0 || cpu_mem_read_data !== mem_read_data) begin
                errors++;
                $display("FAIL error_sticky[%0d]: got err=%b rdy=%b mw=%b mr=%b", i,
                         error, in_ready, mem_write, mem_read);
            end
        end
        do_reset();
        #1;
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL error_clear: got err=%b rdy=%b want 0 1", error, in_ready);
        end
    endtask

    task automatic test_max_length();
        byte_q_t s;
        do_reset();
        s.push_back(8'h01);
        s.push_back(8'h00);
        for (int i = 0; i < 512; i++) s.push_back(8'($urandom));
        test_load_stream("max_len", s, 0);
    endtask

    task automatic test_abort();
        int wb;
        do_reset();
        wb = wr_addr_log.size();
        send_stream("abort_prefix", pack_stream(64'h0003_12, 3), 0);
        do_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (wr_addr_log.size() != wb) begin
            errors++;
            $display("FAIL abort_no_write: got %0d writes want 0", wr_addr_log.size() - wb);
        end
        test_load_stream("after_abort", pack_stream(64'h0001_5566, 4), 0);
    endtask

    task automatic test_random_gaps();
        byte_q_t s;
        int      n;
        do_reset();
        test_load_stream("gaps", pack_stream(64'h0002_1234_ABCD, 6), 3);
        for (int k = 0; k < 4; k++) begin
            do_reset();
            n = int'($urandom_range(12, 1));
            s.delete();
            s.push_back(8'h00);
            s.push_back(8'(n));
            for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
            test_load_stream("rand_stream", s, 2);
        end
    endtask

    initial begin
        mem_read_data = WS'($urandom);
        test_reset();
        test_basic();
        test_run_passthrough();
        test_halt_reload();
        test_empty();
        test_overflow();
        test_max_length();
        test_abort();
        test_random_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
